// File: rtl/pe_out_drain_pkg.sv
// Shared definitions for the PE array result path.
// Purpose: defines the tile geometry and packing once so that the PE array
// and the drain block agree on where row r / lane n lives inside a tile:
// lane n of row r sits at bits (r*PE_COL+n)*PE_DW +: PE_DW.
// Contents: geometry localparams, lane/row/tile typedefs, drain FSM state
// encoding and a helper for index widths.
package pe_out_drain_pkg;

  localparam int PE_COL   = 16;
  localparam int PE_ROW   = 2;
  localparam int PE_DW    = 16;
  localparam int PE_DEPTH = 2;

  typedef logic [PE_DW-1:0]  lane_t;
  typedef lane_t [PE_COL-1:0] row_t;
  typedef row_t  [PE_ROW-1:0] tile_t;

  // Occupancy view of the tile buffer, exposed for debug/checkers.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FULL  = 2'd2
  } drain_state_e;

  // Width of a row index; a single-row tile still gets a 1-bit index.
  function automatic int row_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/pe_out_drain_if.sv
// Tile capture + row-beat output bus of the drain block.
// Handshakes: both streams use strict valid/ready. A transfer happens on a
// rising clk edge where valid and ready are both high; once valid is high
// the producer holds valid and its payload unchanged until that transfer.
// cap_*: PE array -> drain, one whole tile per transfer.
// out_*: drain -> output buffer, one row (COL lanes) per transfer, with the
//        row index and a last-row marker.
// Modports: master = environment side (PE array / output buffer),
//           slave  = the drain block.
interface pe_out_drain_if
  import pe_out_drain_pkg::*;
#(
  parameter int COL = PE_COL,
  parameter int ROW = PE_ROW,
  parameter int DW  = PE_DW
) ();

  localparam int RW = row_w(ROW);

  logic                  cap_valid;
  logic                  cap_ready;
  logic [ROW*COL*DW-1:0] cap_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [COL*DW-1:0]     out_data;
  logic [RW-1:0]         out_row;
  logic                  out_last;

  modport master (
    output cap_valid, cap_data, out_ready,
    input  cap_ready, out_valid, out_data, out_row, out_last
  );

  modport slave (
    input  cap_valid, cap_data, out_ready,
    output cap_ready, out_valid, out_data, out_row, out_last
  );

endinterface

// File: rtl/pe_out_drain_fifo.sv
// pe_tile_fifo: circular buffer of DEPTH whole tiles.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push       write push_data into slot wr_ptr (ignored when full)
//   push_data  tile to store
//   pop        retire slot rd_ptr (ignored when empty)
//   rd_data    contents of slot rd_ptr (valid or not)
//   count      number of stored tiles, 0..DEPTH
// DEPTH is a power of two so the pointers wrap by natural overflow.
module pe_tile_fifo #(
  parameter int TW    = 512,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [TW-1:0]                push_data,
  input  logic                         pop,
  output logic [TW-1:0]                rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [TW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pe_out_drain.sv
// pe_out_drain: captures finished result tiles from the PE array, buffers
// up to DEPTH of them and drains each tile one row per beat.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (drops all buffered tiles)
//   bus        pe_out_drain_if.slave: cap_* tile capture, out_* row beats
//   ovf        sticky, set when a tile is offered while the buffer is full
//   tile_cnt   number of tiles whose last row has been accepted (wraps)
// cap_ready and out_valid come straight from the registered occupancy
// state, so a pop never frees a slot for a capture in the same cycle.
module pe_out_drain
  import pe_out_drain_pkg::*;
#(
  parameter int COL   = PE_COL,
  parameter int ROW   = PE_ROW,
  parameter int DW    = PE_DW,
  parameter int DEPTH = PE_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  pe_out_drain_if.slave bus,
  output logic          ovf,
  output logic [15:0]   tile_cnt
);

  localparam int RW = row_w(ROW);
  localparam int BW = COL * DW;
  localparam int TW = ROW * BW;
  localparam int CW = $clog2(DEPTH+1);

  drain_state_e  state;
  logic [CW-1:0] count;
  logic [TW-1:0] rd_tile;
  logic [RW-1:0] row_idx;
  logic          last_row;
  logic          cap_fire;
  logic          beat_fire;
  logic          tile_done;

  assign bus.cap_ready = (state != ST_FULL);
  assign bus.out_valid = (state != ST_EMPTY);
  assign bus.out_data  = rd_tile[row_idx*BW +: BW];
  assign bus.out_row   = row_idx;
  assign last_row      = (row_idx == RW'(ROW-1));
  assign bus.out_last  = last_row & bus.out_valid;

  assign cap_fire  = bus.cap_valid & bus.cap_ready;
  assign beat_fire = bus.out_valid & bus.out_ready;
  assign tile_done = beat_fire & last_row;

  pe_tile_fifo #(
    .TW    (TW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cap_fire),
    .push_data (bus.cap_data),
    .pop       (tile_done),
    .rd_data   (rd_tile),
    .count     (count)
  );

  // Occupancy FSM tracks the fifo count; DEPTH >= 2 so an empty buffer
  // always moves to DRAIN first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (cap_fire) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (cap_fire && !tile_done && count == CW'(DEPTH-1))
            state <= ST_FULL;
          else if (tile_done && !cap_fire && count == CW'(1))
            state <= ST_EMPTY;
        end
        ST_FULL:  if (tile_done) state <= ST_DRAIN;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  // Row sequencer plus debug counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_idx  <= '0;
      ovf      <= 1'b0;
      tile_cnt <= '0;
    end else begin
      if (beat_fire) row_idx <= last_row ? '0 : row_idx + RW'(1);
      if (bus.cap_valid && !bus.cap_ready) ovf <= 1'b1;
      if (tile_done) tile_cnt <= tile_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pe_out_drain.sv
// Testbench for pe_out_drain: directed scenarios followed by random traffic.
// The reference model is a queue of expected row beats plus a count of
// tiles still resident; both are updated from the handshake rules.
module tb_pe_out_drain;
  import pe_out_drain_pkg::*;

  localparam int DEPTH = PE_DEPTH;
  localparam int BW    = PE_COL * PE_DW;
  localparam int RW    = row_w(PE_ROW);
  localparam int EW    = 1 + RW + BW;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        ovf;
  logic [15:0] tile_cnt;

  always #5 clk = ~clk;

  pe_out_drain_if bus ();

  pe_out_drain dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ovf      (ovf),
    .tile_cnt (tile_cnt)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            m_tiles;
  logic          m_ovf;
  logic [15:0]   m_cnt;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- monitor / reference model ----------------
  // At each falling edge: compare DUT outputs with the model, then apply
  // what the next rising edge will commit (inputs are stable here).
  always @(negedge clk) begin
    logic [EW-1:0] b;
    logic          cap_ok;
    if (rst) begin
      exp_q.delete();
      m_tiles = 0;
      m_ovf   = 1'b0;
      m_cnt   = '0;
      chk("rst_cap_ready", EW'(bus.cap_ready), EW'(1'b1));
      chk("rst_out_valid", EW'(bus.out_valid), EW'(1'b0));
      chk("rst_out_row",   EW'(bus.out_row),   EW'(1'b0));
      chk("rst_ovf",       EW'(ovf),           EW'(1'b0));
      chk("rst_tile_cnt",  EW'(tile_cnt),      EW'(16'd0));
    end else begin
      chk("cap_ready", EW'(bus.cap_ready), EW'(m_tiles < DEPTH));
      chk("out_valid", EW'(bus.out_valid), EW'(m_tiles > 0));
      chk("ovf",       EW'(ovf),           EW'(m_ovf));
      chk("tile_cnt",  EW'(tile_cnt),      EW'(m_cnt));
      if (m_tiles > 0)
        chk("beat", {bus.out_last, bus.out_row, bus.out_data}, exp_q[0]);
      else
        chk("idle_out_last", EW'(bus.out_last), EW'(1'b0));

      cap_ok = bus.cap_valid && (m_tiles < DEPTH);
      if (bus.cap_valid && !cap_ok) m_ovf = 1'b1;
      if (cap_ok) begin
        tile_t t;
        t = tile_t'(bus.cap_data);
        for (int r = 0; r < PE_ROW; r++)
          exp_q.push_back({(r == PE_ROW-1) ? 1'b1 : 1'b0, RW'(r), t[r]});
      end
      if (m_tiles > 0 && bus.out_ready) begin
        b = exp_q.pop_front();
        if (b[EW-1]) begin
          m_tiles--;
          m_cnt = m_cnt + 16'd1;
        end
      end
      if (cap_ok) m_tiles++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic tile_t pat_tile(input int k);
    tile_t t;
    for (int r = 0; r < PE_ROW; r++)
      for (int n = 0; n < PE_COL; n++)
        t[r][n] = lane_t'(k*4096 + r*256 + n);
    return t;
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int r = 0; r < PE_ROW; r++)
      for (int n = 0; n < PE_COL; n++)
        t[r][n] = lane_t'($urandom);
    return t;
  endfunction

  task automatic send(input tile_t t);
    bus.cap_valid = 1'b1;
    bus.cap_data  = t;
    tick();
    bus.cap_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    bus.cap_valid = 1'b0;
    bus.cap_data  = '0;
    bus.out_ready = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(10);

    // Single tile, free-flowing output.
    bus.out_ready = 1'b1;
    send(pat_tile(0));
    idle(4);

    // Backpressure: beat0 must hold for 5 cycles.
    bus.out_ready = 1'b0;
    send(pat_tile(1));
    idle(5);
    bus.out_ready = 1'b1;
    idle(3);

    // Fill: third back-to-back tile is dropped and sets ovf.
    bus.out_ready = 1'b0;
    send(pat_tile(2));
    send(pat_tile(3));
    send(pat_tile(4));
    idle(2);
    bus.out_ready = 1'b1;
    idle(6);

    // Full + last-beat pop in the same cycle.
    pulse_reset();
    bus.out_ready = 1'b0;
    send(pat_tile(5));
    send(pat_tile(6));
    bus.out_ready = 1'b1;
    tick();                 // beat0 of tile 5
    send(pat_tile(7));      // offered during last-beat pop: dropped
    send(pat_tile(8));      // accepted next cycle
    idle(8);

    // Reset mid-drain.
    bus.out_ready = 1'b0;
    send(pat_tile(9));
    send(pat_tile(10));
    bus.out_ready = 1'b1;
    tick();                 // beat0 of tile 9
    bus.out_ready = 1'b0;
    pulse_reset();
    bus.out_ready = 1'b1;
    idle(3);
    send(pat_tile(11));
    idle(4);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bus.cap_valid = ($urandom_range(0, 9) < 4);
      bus.cap_data  = rand_tile();
      bus.out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    bus.cap_valid = 1'b0;
    bus.out_ready = 1'b1;
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
